input_action_conditioner: RTL and testbench

//  Parametrised N-channel front end for the push-button inputs (left/right/rotate/...).
//  Per channel: synchronise the raw button, debounce it and emit a one-cycle press pulse.

---
 rtl/tetris_input_pkg.sv | 30 +++
 rtl/debounce_channel.sv | 119 +++++++++++
 rtl/input_action_conditioner.sv | 116 +++++++++++
 tb/tb_input_action_conditioner.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_input_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : tetris_input_pkg
//  Description : Action ids and width helper shared by the input conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_input_pkg;

    localparam int ACT_LEFT  = 0;
    localparam int ACT_RIGHT = 1;
    localparam int ACT_ROT   = 2;
    localparam int ACT_DROP  = 3;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_e;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : Synchroniser, debounce counter, level/pulse and optional
//                auto-repeat (built only when AUTOREPEAT_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import tetris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = 500000,
    parameter int ACTIVE_LOW    = 1,
    parameter int RPT_DELAY_CYC = 12500000,
    parameter int RPT_RATE_CYC  = 2500000,
    parameter int RPT_EN        = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

`ifdef AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);
    localparam int   CW           = clog2_min1(DEBOUNCE_CYC);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          sync_pressed;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          pulse_q;
    logic          rise;
    logic          rpt_fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= RELEASED_RAW;
            sync2_q <= RELEASED_RAW;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign sync_pressed = sync2_q ^ RELEASED_RAW;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_pressed != level_q) begin
            if (cnt_q == DEB_LAST) begin
                level_d = sync_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rise = level_d & ~level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= rise | rpt_fire;
        end
    end

    generate
        if (AUTOREPEAT && (RPT_EN != 0)) begin : g_rpt
            localparam int RMAX = (RPT_DELAY_CYC > RPT_RATE_CYC) ? RPT_DELAY_CYC : RPT_RATE_CYC;
            localparam int RW   = clog2_min1(RMAX);

            logic [RW-1:0] rcnt_q;
            logic          first_done_q;
            logic [RW-1:0] limit;

            // First repeat waits the long delay, later ones use the rate.
            assign limit    = first_done_q ? RW'(RPT_RATE_CYC - 1) : RW'(RPT_DELAY_CYC - 1);
            assign rpt_fire = level_q & (rcnt_q == limit);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rcnt_q       <= '0;
                    first_done_q <= 1'b0;
                end else if (!level_q) begin
                    rcnt_q       <= '0;
                    first_done_q <= 1'b0;
                end else if (rpt_fire) begin
                    rcnt_q       <= '0;
                    first_done_q <= 1'b1;
                end else begin
                    rcnt_q       <= rcnt_q + 1'b1;
                end
            end
        end else begin : g_no_rpt
            assign rpt_fire = 1'b0;
        end
    endgenerate

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/input_action_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_action_conditioner
//  Description : N-channel button front end: per-channel debounce, pending
//                latches and a lowest-index valid/ready action arbiter.
//                Optional auto-repeat is enabled by defining AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_action_conditioner
    import tetris_input_pkg::*;
#(
    parameter int              N_CH          = 3,
    parameter int              DEBOUNCE_CYC  = 500000,
    parameter int              ACTIVE_LOW    = 1,
    parameter int              RPT_DELAY_CYC = 12500000,
    parameter int              RPT_RATE_CYC  = 2500000,
    parameter logic [N_CH-1:0] RPT_MASK      = N_CH'(3'b011)
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [N_CH-1:0]               btn_raw,
    output logic [N_CH-1:0]               level,
    output logic [N_CH-1:0]               pulse,
    output logic                          act_valid,
    output logic [clog2_min1(N_CH)-1:0]   act_id,
    input  logic                          act_ready
);

    localparam int AW = clog2_min1(N_CH);

    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] pulse_w;
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] pend_d;
    logic [N_CH-1:0] avail;
    logic [N_CH-1:0] accept_oh;
    logic [AW-1:0]   first_idx;
    logic            any_avail;
    logic            accept;
    arb_state_e      state_q;
    logic            act_valid_q;
    logic [AW-1:0]   act_id_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYC  (DEBOUNCE_CYC),
                .ACTIVE_LOW    (ACTIVE_LOW),
                .RPT_DELAY_CYC (RPT_DELAY_CYC),
                .RPT_RATE_CYC  (RPT_RATE_CYC),
                .RPT_EN        (RPT_MASK[gi] ? 1 : 0)
            ) u_chan (
                .clk_i   (CLOCK_50),
                .rst_i   (reset),
                .raw_i   (btn_raw[gi]),
                .level_o (level_w[gi]),
                .pulse_o (pulse_w[gi])
            );
        end
    endgenerate

    assign accept = act_valid_q & act_ready;

    // A pulse in flight counts as pending so it can be presented one edge later.
    always_comb begin
        avail     = pend_q | pulse_w;
        first_idx = '0;
        any_avail = 1'b0;
        accept_oh = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (avail[i]) begin
                first_idx = AW'(i);
                any_avail = 1'b1;
            end
            accept_oh[i] = accept && (act_id_q == AW'(i));
        end
        pend_d = (pend_q & ~accept_oh) | pulse_w;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            act_valid_q <= 1'b0;
            act_id_q    <= '0;
            pend_q      <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                ARB_IDLE: begin
                    if (any_avail) begin
                        state_q     <= ARB_PRESENT;
                        act_valid_q <= 1'b1;
                        act_id_q    <= first_idx;
                    end
                end
                ARB_PRESENT: begin
                    if (act_ready) begin
                        state_q     <= ARB_IDLE;
                        act_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    act_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign level     = level_w;
    assign pulse     = pulse_w;
    assign act_valid = act_valid_q;
    assign act_id    = act_id_q;

endmodule
`default_nettype wire

// File: tb/tb_input_action_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_action_conditioner
//  Description : Self-checking bench for input_action_conditioner with a
//                per-cycle reference model plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_input_action_conditioner;

    localparam int N  = 3;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;
    localparam logic [2:0] MASK = 3'b011;
`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_raw = 3'b111;
    logic       act_ready = 1'b0;
    logic [2:0] level;
    logic [2:0] pulse;
    logic       act_valid;
    logic [1:0] act_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepts = 0;

    input_action_conditioner #(
        .N_CH(N), .DEBOUNCE_CYC(DB), .ACTIVE_LOW(1),
        .RPT_DELAY_CYC(RD), .RPT_RATE_CYC(RR), .RPT_MASK(MASK)
    ) dut (
        .CLOCK_50(clk), .reset(rst), .btn_raw(btn_raw), .level(level),
        .pulse(pulse), .act_valid(act_valid), .act_id(act_id), .act_ready(act_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (!rst && act_valid && act_ready) accepts++;
    end

    // Reference model: raw reaches the debouncer two edges late; level flips after
    // DB consecutive mismatching edges; repeats fire by elapsed held time.
    bit m_s1[N], m_s2[N], m_lvl[N], m_pulse[N], m_pend[N], m_np[N];
    int m_run[N], m_held[N];
    bit m_valid, m_acc, m_new;
    int m_id;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pulse[i] = 0;
                m_pend[i] = 0; m_run[i] = 0; m_held[i] = 0;
            end
            m_valid = 0; m_id = 0;
        end else begin
            m_acc = m_valid && act_ready;
            for (int i = 0; i < N; i++)
                m_np[i] = (m_pend[i] && !(m_acc && m_id == i)) || m_pulse[i];
            if (m_acc) begin
                m_valid = 0;
            end else if (!m_valid) begin
                for (int i = N - 1; i >= 0; i--)
                    if (m_pend[i] || m_pulse[i]) begin m_valid = 1; m_id = i; end
            end
            for (int i = 0; i < N; i++) begin
                m_pend[i] = m_np[i];
                m_new = 0;
                if (m_lvl[i]) begin
                    m_held[i]++;
                    if (AR && MASK[i] && (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RR == 0)))
                        m_new = 1;
                end else begin
                    m_held[i] = 0;
                end
                if (m_s2[i] != m_lvl[i]) m_run[i]++;
                else                     m_run[i] = 0;
                if (m_run[i] == DB) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                    if (m_s2[i]) m_new = 1;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = (btn_raw[i] == 1'b0);
                m_pulse[i] = m_new;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("model_level%0d", i), 32'(level[i]), 32'(m_lvl[i]));
                chk($sformatf("model_pulse%0d", i), 32'(pulse[i]), 32'(m_pulse[i]));
            end
            chk("model_act_valid", 32'(act_valid), 32'(m_valid));
            if (m_valid) chk("model_act_id", 32'(act_id), 32'(m_id));
        end
    end

    task automatic wait_valid(input int maxc);
        int k;
        k = 0;
        while (act_valid !== 1'b1 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (act_valid !== 1'b1) chk("wait_valid_timeout", 32'(act_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int base;
    int seen;
    int k;
    int first;
    int offs[$];

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_pulse", 32'(pulse), 32'd0);
        chk("reset_valid", 32'(act_valid), 32'd0);
        chk("reset_id", 32'(act_id), 32'd0);
        rst = 1'b0;

        // 1: clean press of ch0 just before edge 10
        while (cyc != 9) @(negedge clk);
        btn_raw[0] = 1'b0;
        while (cyc < 16) begin
            @(negedge clk);
            if (cyc == 14) chk("t1_pulse_e14", 32'(pulse[0]), 32'd0);
            if (cyc == 15) begin
                chk("t1_pulse_e15", 32'(pulse[0]), 32'd1);
                chk("t1_level_e15", 32'(level[0]), 32'd1);
                chk("t1_valid_e15", 32'(act_valid), 32'd0);
            end
            if (cyc == 16) begin
                chk("t1_pulse_e16", 32'(pulse[0]), 32'd0);
                chk("t1_valid_e16", 32'(act_valid), 32'd1);
                chk("t1_id_e16", 32'(act_id), 32'd0);
            end
        end
        act_ready = 1'b1;
        btn_raw[0] = 1'b1;
        repeat (12) @(negedge clk);
        act_ready = 1'b0;

        // 2: 3-cycle glitch on ch1
        btn_raw[1] = 1'b0;
        repeat (3) @(negedge clk);
        btn_raw[1] = 1'b1;
        seen = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (level[1] || pulse[1] || act_valid) seen = 1;
        end
        chk("t2_glitch_activity", 32'(seen), 32'd0);

        // 3: ch2 then ch0 with ready low, then ready high
        btn_raw[2] = 1'b0;
        repeat (2) @(negedge clk);
        btn_raw[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t3_valid_first", 32'(act_valid), 32'd1);
        chk("t3_id_first", 32'(act_id), 32'd2);
        repeat (5) @(negedge clk);
        chk("t3_id_held", 32'(act_id), 32'd2);
        act_ready = 1'b1;
        @(negedge clk);
        chk("t3_valid_gap", 32'(act_valid), 32'd0);
        @(negedge clk);
        chk("t3_valid_second", 32'(act_valid), 32'd1);
        chk("t3_id_second", 32'(act_id), 32'd0);
        @(negedge clk);
        chk("t3_valid_drained", 32'(act_valid), 32'd0);
        btn_raw[0] = 1'b1;
        btn_raw[2] = 1'b1;
        act_ready = 1'b0;
        repeat (12) @(negedge clk);

        // 4: ch1 pulses in the cycle its pending action is accepted
        base = accepts;
        btn_raw[1] = 1'b0;
        wait_valid(20);
        chk("t4_id_first", 32'(act_id), 32'd1);
        btn_raw[1] = 1'b1;
        repeat (10) @(negedge clk);
        btn_raw[1] = 1'b0;
        k = 0;
        while (pulse[1] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (pulse[1] !== 1'b1) chk("t4_pulse_timeout", 32'(pulse[1]), 32'd1);
        act_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid_gap", 32'(act_valid), 32'd0);
        @(negedge clk);
        chk("t4_valid_again", 32'(act_valid), 32'd1);
        chk("t4_id_again", 32'(act_id), 32'd1);
        repeat (6) @(negedge clk);
        chk("t4_valid_end", 32'(act_valid), 32'd0);
        chk("t4_accepts", 32'(accepts - base), 32'd2);
        act_ready = 1'b0;
        btn_raw[1] = 1'b1;
        repeat (12) @(negedge clk);

        // 5: reset while an action is presented and ch0 is mid-debounce
        btn_raw[1] = 1'b0;
        wait_valid(20);
        btn_raw[1] = 1'b1;
        repeat (10) @(negedge clk);
        btn_raw[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_level_rst", 32'(level), 32'd0);
        chk("t5_pulse_rst", 32'(pulse), 32'd0);
        chk("t5_valid_rst", 32'(act_valid), 32'd0);
        chk("t5_id_rst", 32'(act_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        btn_raw[0] = 1'b1;
        seen = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (pulse != 3'b000 || act_valid) seen = 1;
        end
        chk("t5_no_pulse_after_rst", 32'(seen), 32'd0);

        // 6: long hold of ch0 (repeat-eligible) and ch2 (masked out)
        act_ready = 1'b1;
        btn_raw[0] = 1'b0;
        first = -1;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            if (pulse[0]) begin
                if (first < 0) first = j;
                if (j - first <= 55) offs.push_back(j - first);
            end
        end
        btn_raw[0] = 1'b1;
`ifdef AUTOREPEAT_EN
        chk("t6_ch0_pulse_count", 32'(offs.size()), 32'd6);
        if (offs.size() == 6) begin
            chk("t6_ch0_first_repeat", 32'(offs[1]), 32'd20);
            chk("t6_ch0_last_repeat", 32'(offs[5]), 32'd52);
        end
`else
        chk("t6_ch0_pulse_count", 32'(offs.size()), 32'd1);
`endif
        repeat (12) @(negedge clk);
        btn_raw[2] = 1'b0;
        seen = 0;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            if (pulse[2]) seen++;
        end
        btn_raw[2] = 1'b1;
        chk("t6_ch2_pulse_count", 32'(seen), 32'd1);
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
